// File: rtl/bios_mem_arbiter_pkg.sv
// Shared types and default parameters for the BIOS memory arbiter.
package bios_arb_pkg;

  // Which requester owns the read response returning next cycle
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int DEFAULT_ADDR_WIDTH     = 12;
  localparam int DEFAULT_MAX_DATA_BURST = 4;

endpackage

// File: rtl/bios_mem_arbiter_if.sv
// Memory command/response bundle between the arbiter and a single-port BIOS memory.
interface bios_mem_arbiter_if #(
  parameter int ADDR_WIDTH = bios_arb_pkg::DEFAULT_ADDR_WIDTH
);
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  // Arbiter side issues commands and receives read data
  modport master (
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  // Memory side accepts commands and returns read data one cycle later
  modport slave (
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/bios_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port BIOS memory.
// Data normally wins; a saturating counter of contended data grants forces a fetch
// grant once it reaches MAX_DATA_BURST so fetch cannot starve.
module bios_mem_arbiter
  import bios_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int MAX_DATA_BURST = DEFAULT_MAX_DATA_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_req_ready,
  input  logic                  if_flush,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_we,
  input  logic [31:0]           d_wdata,
  output logic                  d_req_ready,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_BURST);

  logic       fetch_grant;
  logic       data_grant;
  logic       starve_hit;
  logic [3:0] cnt_q, cnt_d;
  owner_e     owner_q, owner_d;

  // Grant decision: fetch only when data is idle or fetch has been starved long enough
  always_comb begin
    fetch_grant = 1'b0;
    data_grant  = 1'b0;
    starve_hit  = (cnt_q == MAX_CNT);
    if (rst) begin
      if (if_req_valid && !if_flush && (!d_req_valid || starve_hit)) begin
        fetch_grant = 1'b1;
      end else if (d_req_valid) begin
        data_grant = 1'b1;
      end
    end
  end

  // Starvation counter: counts data grants that held off a live fetch request
  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant || !if_req_valid) begin
      cnt_d = 4'd0;
    end else if (data_grant && !if_flush && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Next owner of the read response: only read grants return data
  always_comb begin
    owner_d = OWN_NONE;
    if (fetch_grant) begin
      owner_d = OWN_FETCH;
    end else if (data_grant && (d_we == 4'b0000)) begin
      owner_d = OWN_DATA;
    end
  end

  // State registers; reset drops any outstanding response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      owner_q <= OWN_NONE;
    end else begin
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  // Memory command steered from the granted port in the same cycle
  always_comb begin
    mem_en   = fetch_grant || data_grant;
    mem_we   = data_grant ? d_we : 4'b0000;
    mem_addr = fetch_grant ? if_addr : d_addr;
    mem_din  = data_grant ? d_wdata : 32'd0;
  end

  // Handshakes and responses; a flush kills a fetch response due this cycle
  always_comb begin
    if_req_ready = fetch_grant;
    d_req_ready  = data_grant;
    if_rvalid    = (owner_q == OWN_FETCH) && !if_flush;
    d_rvalid     = (owner_q == OWN_DATA);
    if_rdata     = mem_dout;
    d_rdata      = mem_dout;
  end

endmodule

// File: tb/tb_bios_mem_arbiter.sv
// Directed testbench for bios_mem_arbiter with a small byte-masked memory model.
module tb_bios_mem_arbiter;

  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          if_req_valid;
  logic [AW-1:0] if_addr;
  logic          if_req_ready;
  logic          if_flush;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req_valid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_we;
  logic [31:0]   d_wdata;
  logic          d_req_ready;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic [31:0]   memArray [0:(1<<AW)-1];
  int            checkCount;
  int            errorCount;

  bios_mem_arbiter_if #(.ADDR_WIDTH(AW)) memIf ();

  bios_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_DATA_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_addr      (if_addr),
    .if_req_ready (if_req_ready),
    .if_flush     (if_flush),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req_valid  (d_req_valid),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_wdata      (d_wdata),
    .d_req_ready  (d_req_ready),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_en       (memIf.mem_en),
    .mem_we       (memIf.mem_we),
    .mem_addr     (memIf.mem_addr),
    .mem_din      (memIf.mem_din),
    .mem_dout     (memIf.mem_dout)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port memory model: one-cycle read latency, byte-masked writes
  initial begin
    for (int k = 0; k < (1<<AW); k++) memArray[k] = 32'hC0DE_0000 | k;
    memIf.mem_dout = 32'd0;
  end

  always @(posedge clk) begin
    if (memIf.mem_en) begin
      if (memIf.mem_we == 4'b0000) begin
        memIf.mem_dout <= memArray[memIf.mem_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (memIf.mem_we[b]) memArray[memIf.mem_addr][b*8 +: 8] <= memIf.mem_din[b*8 +: 8];
      end
    end
  end

  // Counts one comparison and reports it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of request inputs right after a falling edge, then settles
  task automatic applyStimulus(input logic ifv, input logic [AW-1:0] ia, input logic fl,
                               input logic dv, input logic [AW-1:0] da,
                               input logic [3:0] we, input logic [31:0] wd);
    @(negedge clk);
    if_req_valid = ifv;
    if_addr      = ia;
    if_flush     = fl;
    d_req_valid  = dv;
    d_addr       = da;
    d_we         = we;
    d_wdata      = wd;
    #1;
  endtask

  initial begin
    logic expFetch;
    logic prevFetch;
    logic prevData;
    checkCount   = 0;
    errorCount   = 0;
    rst          = 1'b0;
    if_req_valid = 1'b1;
    if_addr      = '0;
    if_flush     = 1'b0;
    d_req_valid  = 1'b1;
    d_addr       = '0;
    d_we         = 4'b0000;
    d_wdata      = 32'd0;

    // Reset holds every handshake and command low even with requests pending
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
    checkOutput("rst_d_ready",  {31'd0, d_req_ready},  32'd0);
    checkOutput("rst_mem_en",   {31'd0, memIf.mem_en}, 32'd0);
    checkOutput("rst_mem_we",   {28'd0, memIf.mem_we}, 32'd0);
    checkOutput("rst_rvalids",  {30'd0, if_rvalid, d_rvalid}, 32'd0);

    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 4'b0000, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);

    // Fetch-only stream of addresses 0..3, responses one cycle later in order
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i < 4, AW'(i), 1'b0, 1'b0, '0, 4'b0000, 32'd0);
      checkOutput($sformatf("fetch_ready_%0d", i), {31'd0, if_req_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) checkOutput($sformatf("fetch_addr_%0d", i), 32'(memIf.mem_addr), 32'(i));
      if (i > 0) begin
        checkOutput($sformatf("fetch_rvalid_%0d", i), {31'd0, if_rvalid}, 32'd1);
        checkOutput($sformatf("fetch_rdata_%0d", i), if_rdata, 32'hC0DE_0000 | (i - 1));
      end
    end

    // Both requesting continuously: D,D,D,D,F repeating
    prevFetch = 1'b0;
    prevData  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, AW'(16 + k), 1'b0, 1'b1, AW'(32 + k), 4'b0000, 32'd0);
      expFetch = ((k % 5) == 4);
      checkOutput($sformatf("burst_if_ready_%0d", k), {31'd0, if_req_ready}, {31'd0, expFetch});
      checkOutput($sformatf("burst_d_ready_%0d", k),  {31'd0, d_req_ready},  {31'd0, !expFetch});
      if (k > 0) begin
        checkOutput($sformatf("burst_rvalids_%0d", k), {30'd0, if_rvalid, d_rvalid},
                    {30'd0, prevFetch, prevData});
      end
      prevFetch = expFetch;
      prevData  = !expFetch;
    end

    // Byte-masked write: command passes through, no read response follows
    applyStimulus(1'b0, '0, 1'b0, 1'b1, AW'(5), 4'b0011, 32'hAABBCCDD);
    checkOutput("wr_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    checkOutput("wr_d_ready", {31'd0, d_req_ready}, 32'd1);
    checkOutput("wr_mem_we",  {28'd0, memIf.mem_we}, 32'h3);
    checkOutput("wr_mem_din", memIf.mem_din, 32'hAABBCCDD);
    checkOutput("wr_mem_addr", 32'(memIf.mem_addr), 32'd5);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, AW'(5), 4'b0000, 32'd0);
    checkOutput("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    checkOutput("rd5_mem_we", {28'd0, memIf.mem_we}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 4'b0000, 32'd0);
    checkOutput("rd5_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("rd5_rdata", d_rdata, 32'hC0DE_CCDD);
    checkOutput("idle_mem_en", {31'd0, memIf.mem_en}, 32'd0);

    // Flush kills the fetch response and blocks fetch, data still gets through
    applyStimulus(1'b1, AW'(8), 1'b0, 1'b0, '0, 4'b0000, 32'd0);
    checkOutput("fl_fetch_ready", {31'd0, if_req_ready}, 32'd1);
    applyStimulus(1'b1, AW'(8), 1'b1, 1'b1, AW'(9), 4'b0000, 32'd0);
    checkOutput("fl_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    checkOutput("fl_if_ready",  {31'd0, if_req_ready}, 32'd0);
    checkOutput("fl_d_ready",   {31'd0, d_req_ready}, 32'd1);
    applyStimulus(1'b1, AW'(10), 1'b1, 1'b0, '0, 4'b0000, 32'd0);
    checkOutput("fl_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("fl_d_rdata", d_rdata, 32'hC0DE_0009);
    checkOutput("fl_only_mem_en", {31'd0, memIf.mem_en}, 32'd0);

    // Reset right after a data read grant drops the response
    applyStimulus(1'b0, '0, 1'b0, 1'b1, AW'(2), 4'b0000, 32'd0);
    checkOutput("rr_d_ready", {31'd0, d_req_ready}, 32'd1);
    applyStimulus(1'b1, AW'(3), 1'b0, 1'b1, AW'(4), 4'b0000, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rr_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    checkOutput("rr_outputs", {26'd0, if_req_ready, d_req_ready, if_rvalid, d_rvalid,
                memIf.mem_en, |memIf.mem_we}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 4'b0000, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rr_release_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 4'b0000, 32'd0);
    checkOutput("rr_after_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
